// File: rtl/sl3p_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sl3p_chk_pkg
//  Brief    : Shared types and constants for the SL3 lane checker controller.
//  Revision : 1.0 - initial release
// ============================================================================
package sl3p_chk_pkg;

    // Lock controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        HALT   = 2'd3
    } state_t;

    // Counter widths
    localparam int RUN_W   = 8;
    localparam int WIN_W   = 16;
    localparam int ERR_W   = 16;

    // Comparator pipeline depth (word in -> aligned mismatch out)
    localparam int CMP_LAT = 3;

    // Saturating increment for the run / window-error counters
    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating increment for the total-error counter
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mismatch_32.sv
`default_nettype none
// ============================================================================
//  Module   : mismatch_32
//  Brief    : 32-bit word comparator, 3-cycle latency, no reset. The first
//             stage only loads on valid words; downstream validity is tracked
//             by the user.
//  Revision : 1.0 - initial release
// ============================================================================
module mismatch_32 #(
    parameter int TARGET_CHIP = 2
) (
    input  logic        clk,
    input  logic        din_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        mismatch
);

    // Larger targets reduce in narrower groups to keep the OR tree shallow
    localparam int GRP  = (TARGET_CHIP >= 2) ? 4 : 8;
    localparam int NGRP = 32 / GRP;

    logic [31:0]     diff_q;
    logic [NGRP-1:0] grp_or;
    logic [NGRP-1:0] grp_q;
    logic            mismatch_q;

    // Stage 1: capture bitwise difference of valid words
    always_ff @(posedge clk) begin
        if (din_valid) begin
            diff_q <= a ^ b;
        end
    end

    generate
        for (genvar g = 0; g < NGRP; g++) begin : g_grp
            assign grp_or[g] = |diff_q[g*GRP +: GRP];
        end
    endgenerate

    // Stages 2 and 3: grouped OR, then final OR
    always_ff @(posedge clk) begin
        grp_q      <= grp_or;
        mismatch_q <= |grp_q;
    end

    assign mismatch = mismatch_q;

endmodule
`default_nettype wire

// File: rtl/lane_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lane_check_ctrl
//  Brief    : Lock / error-policy controller for one 32-bit lane checker.
//             Tracks aligned comparator results through IDLE/HUNT/LOCKED/HALT,
//             counts windowed and total errors, and requests reseeds.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_check_ctrl
    import sl3p_chk_pkg::*;
#(
    parameter int TARGET_CHIP = 2,
    parameter int LOCK_RUN    = 64,
    parameter int WIN_LEN     = 1024,
    parameter int WIN_ERRS    = 8,
    parameter int HALT_ERRS   = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [31:0]      rx_data,
    input  logic [31:0]      exp_data,
    input  logic             din_valid,
    output logic             locked,
    output logic             halt,
    output logic             resync,
    output logic [ERR_W-1:0] err_total,
    output logic             err_pulse
);

    logic [CMP_LAT-1:0] vpipe;
    logic               v3;
    logic               mismatch;

    state_t             state;
    state_t             state_n;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_n;
    logic [RUN_W-1:0]   win_err;
    logic [RUN_W-1:0]   win_err_n;
    logic [RUN_W-1:0]   win_err_base;
    logic [WIN_W-1:0]   win_cnt;
    logic [WIN_W-1:0]   win_cnt_n;
    logic [WIN_W-1:0]   win_inc;
    logic [ERR_W-1:0]   tot_n;
    logic               resync_n;
    logic               err_pulse_n;
    logic               roll;
    logic               is_err;
    logic               is_match;
    logic               flush;

    assign v3 = vpipe[CMP_LAT-1];

    mismatch_32 #(
        .TARGET_CHIP (TARGET_CHIP)
    ) u_cmp (
        .clk       (clk),
        .din_valid (din_valid),
        .a         (rx_data),
        .b         (exp_data),
        .mismatch  (mismatch)
    );

    // Next-state and counter update logic driven by aligned results
    always_comb begin
        state_n      = state;
        run_n        = run;
        win_cnt_n    = win_cnt;
        win_err_n    = win_err;
        tot_n        = err_total;
        resync_n     = 1'b0;
        err_pulse_n  = 1'b0;
        is_err       = v3 & mismatch;
        is_match     = v3 & ~mismatch;
        win_inc      = win_cnt + 1'b1;
        roll         = (win_inc == WIN_W'(WIN_LEN));
        // The result that closes a window starts the new one
        win_err_base = roll ? '0 : win_err;

        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_n   = HUNT;
                    run_n     = '0;
                    win_cnt_n = '0;
                    win_err_n = '0;
                    tot_n     = '0;
                end
                HUNT: begin
                    if (clear) begin
                        tot_n = '0;
                    end
                    if (is_err) begin
                        run_n       = '0;
                        // back-to-back errors must not stretch the request
                        resync_n    = ~resync;
                        err_pulse_n = 1'b1;
                    end else if (is_match) begin
                        run_n = sat_inc_run(run);
                        if (run_n == RUN_W'(LOCK_RUN)) begin
                            state_n   = LOCKED;
                            win_cnt_n = '0;
                            win_err_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (v3) begin
                        win_cnt_n = roll ? '0 : win_inc;
                        win_err_n = is_err ? sat_inc_run(win_err_base) : win_err_base;
                    end
                    if (is_err) begin
                        tot_n       = sat_inc_err(err_total);
                        err_pulse_n = 1'b1;
                    end
                    if (clear) begin
                        tot_n = '0;
                    end
                    if (is_err && (tot_n >= ERR_W'(HALT_ERRS))) begin
                        state_n = HALT;
                    end else if (is_err && (win_err_n >= RUN_W'(WIN_ERRS))) begin
                        state_n  = HUNT;
                        resync_n = ~resync;
                        run_n    = '0;
                    end
                end
                HALT: begin
                    if (clear) begin
                        state_n   = HUNT;
                        tot_n     = '0;
                        run_n     = '0;
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        // In-flight words never survive IDLE or HALT
        flush = (state == IDLE) || (state == HALT) ||
                (state_n == IDLE) || (state_n == HALT);
    end

    // State, counters, validity pipeline and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            vpipe     <= '0;
            locked    <= 1'b0;
            halt      <= 1'b0;
            resync    <= 1'b0;
            err_total <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            vpipe     <= flush ? '0 : {vpipe[CMP_LAT-2:0], din_valid};
            locked    <= (state_n == LOCKED);
            halt      <= (state_n == HALT);
            resync    <= resync_n;
            err_total <= tot_n;
            err_pulse <= err_pulse_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_check_ctrl
//  Brief    : Directed self-checking bench for lane_check_ctrl. Instance A
//             uses a short window (16 words / 3 errors), instance B a low
//             halt threshold (5 errors). Both see the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_check_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        din_valid;
    logic [31:0] rx_data;
    logic [31:0] exp_data;

    logic        locked_a, halt_a, resync_a, err_pulse_a;
    logic [15:0] err_total_a;
    logic        locked_b, halt_b, resync_b, err_pulse_b;
    logic [15:0] err_total_b;

    int tests = 0;
    int fails = 0;
    int rs_a  = 0;
    int rs_b  = 0;

    always #5 clk = ~clk;

    lane_check_ctrl #(
        .TARGET_CHIP (2),
        .LOCK_RUN    (64),
        .WIN_LEN     (16),
        .WIN_ERRS    (3),
        .HALT_ERRS   (16'hFFFF)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .rx_data   (rx_data),
        .exp_data  (exp_data),
        .din_valid (din_valid),
        .locked    (locked_a),
        .halt      (halt_a),
        .resync    (resync_a),
        .err_total (err_total_a),
        .err_pulse (err_pulse_a)
    );

    lane_check_ctrl #(
        .TARGET_CHIP (1),
        .LOCK_RUN    (64),
        .WIN_LEN     (1024),
        .WIN_ERRS    (8),
        .HALT_ERRS   (5)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .rx_data   (rx_data),
        .exp_data  (exp_data),
        .din_valid (din_valid),
        .locked    (locked_b),
        .halt      (halt_b),
        .resync    (resync_b),
        .err_total (err_total_b),
        .err_pulse (err_pulse_b)
    );

    // Count resync pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (resync_a) rs_a++;
        if (resync_b) rs_b++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input bit valid, input bit bad);
        rx_data   = $urandom;
        exp_data  = bad ? (rx_data ^ (32'h1 << $urandom_range(31, 0))) : rx_data;
        din_valid = valid;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) word(1'b0, 1'b0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        din_valid = 1'b0;
        rx_data   = '0;
        exp_data  = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic start();
        enable = 1'b1;
        cyc();
    endtask

    task automatic lock_up();
        for (int i = 0; i < 64; i++) word(1'b1, 1'b0);
        idle(3);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_locked_a",    locked_a,    0);
        check("rst_halt_a",      halt_a,      0);
        check("rst_resync_a",    resync_a,    0);
        check("rst_err_total_a", err_total_a, 0);
        check("rst_err_pulse_a", err_pulse_a, 0);
        check("rst_halt_b",      halt_b,      0);

        // ---------------- clean lock ----------------
        rs_a = 0;
        start();
        for (int i = 0; i < 64; i++) word(1'b1, 1'b0);
        idle(2);
        check("clean_not_yet_locked", locked_a, 0);
        idle(1);
        check("clean_locked",    locked_a,    1);
        check("clean_no_resync", rs_a,        0);
        check("clean_err_total", err_total_a, 0);

        // ---------------- hunt error ----------------
        do_reset();
        rs_a = 0;
        start();
        for (int i = 0; i < 10; i++) word(1'b1, 1'b0);
        word(1'b1, 1'b1);
        for (int i = 0; i < 64; i++) begin
            word(1'b1, 1'b0);
            if (i == 1) check("hunt_resync_early", resync_a, 0);
            if (i == 2) begin
                check("hunt_resync_at_t4", resync_a,    1);
                check("hunt_err_pulse",    err_pulse_a, 1);
            end
            if (i == 3) check("hunt_resync_width", resync_a, 0);
        end
        idle(2);
        check("hunt_not_locked_before_run", locked_a, 0);
        idle(1);
        check("hunt_locked_after_run", locked_a, 1);
        check("hunt_resync_count",     rs_a,     1);

        // ---------------- window loss ----------------
        do_reset();
        start();
        lock_up();
        check("win_loss_locked", locked_a, 1);
        rs_a = 0;
        word(1'b1, 1'b1);
        word(1'b1, 1'b0);
        word(1'b1, 1'b0);
        word(1'b1, 1'b1);
        word(1'b1, 1'b0);
        word(1'b1, 1'b0);
        word(1'b1, 1'b1);
        idle(2);
        check("win_loss_pre_locked",    locked_a,    1);
        check("win_loss_pre_err_total", err_total_a, 2);
        idle(1);
        check("win_loss_unlocked",  locked_a,    0);
        check("win_loss_resync",    resync_a,    1);
        check("win_loss_err_total", err_total_a, 3);
        check("win_loss_err_pulse", err_pulse_a, 1);

        // ---------------- window roll ----------------
        do_reset();
        start();
        lock_up();
        rs_a = 0;
        for (int r = 1; r <= 80; r++) begin
            if (r <= 64) word(1'b1, ((r % 16) == 2) || ((r % 16) == 5));
            else         word(1'b1, (r == 78) || (r == 79) || (r == 80));
        end
        idle(3);
        check("roll_locked",     locked_a,    1);
        check("roll_err_total",  err_total_a, 11);
        check("roll_no_resync",  rs_a,        0);
        check("roll_no_halt",    halt_a,      0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clear_locked_zero", err_total_a, 0);
        check("clear_locked_stay", locked_a,    1);

        // ---------------- halt and clear (instance B) ----------------
        do_reset();
        start();
        lock_up();
        check("halt_pre_locked", locked_b, 1);
        rs_b = 0;
        for (int i = 0; i < 5; i++) word(1'b1, 1'b1);
        idle(2);
        check("halt_not_yet", halt_b, 0);
        idle(1);
        check("halt_set",       halt_b,      1);
        check("halt_unlocked",  locked_b,    0);
        check("halt_err_total", err_total_b, 5);
        for (int i = 0; i < 4; i++) word(1'b1, 1'b1);
        idle(4);
        check("halt_frozen_total", err_total_b, 5);
        check("halt_still",        halt_b,      1);
        check("halt_no_err_pulse", err_pulse_b, 0);
        check("halt_no_resync",    rs_b,        0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clear_halt_released", halt_b,      0);
        check("clear_total_zero",    err_total_b, 0);
        check("clear_hunt_unlocked", locked_b,    0);
        lock_up();
        check("clear_relock", locked_b, 1);

        // ---------------- asynchronous reset while locked ----------------
        do_reset();
        start();
        lock_up();
        word(1'b1, 1'b1);
        word(1'b1, 1'b1);
        idle(3);
        check("arst_pre_total",  err_total_a, 2);
        check("arst_pre_locked", locked_a,    1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked",    locked_a,    0);
        check("arst_halt",      halt_a,      0);
        check("arst_resync",    resync_a,    0);
        check("arst_err_total", err_total_a, 0);
        check("arst_err_pulse", err_pulse_a, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // ---------------- disable while locked ----------------
        start();
        lock_up();
        word(1'b1, 1'b1);
        word(1'b1, 1'b1);
        idle(3);
        check("dis_pre_locked", locked_a, 1);
        enable = 1'b0;
        cyc();
        check("dis_unlocked",       locked_a,    0);
        check("dis_total_retained", err_total_a, 2);
        check("dis_no_halt",        halt_a,      0);
        idle(2);
        check("dis_total_hold", err_total_a, 2);
        check("dis_no_resync",  resync_a,    0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_check_ctrl.md
# lane_check_ctrl

Lock and error-policy controller for one 32-bit lane checker in the SL3 user-control path. Each valid cycle it feeds a received word and its expected pattern word into an internal `mismatch_32` comparator (latency 3). It tracks the aligned comparison results through a lock state machine. It also counts errors in a sliding window and in a saturating total, and raises `halt` when the error policy is violated, so the lane can be stopped before FEC is bypassed.

## Interface
- `TARGET_CHIP`, 2: passed to the comparator unchanged.
- `LOCK_RUN`, 64: consecutive matching words needed for HUNT→LOCKED; legal range 1..255.
- `WIN_LEN`, 1024: window length in valid words; legal range 2..65535.
- `WIN_ERRS`, 8: errors within one window that force LOCKED→HUNT; legal range 1..255.
- `HALT_ERRS`, 16'hFFFF: total-error count that forces HALT; legal range 1..65535.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 0 forces IDLE.
- `clear` in 1: one-cycle pulse; leaves HALT and zeroes `err_total`.
- `rx_data` in 32: received word.
- `exp_data` in 32: expected pattern word, aligned with `rx_data`.
- `din_valid` in 1: both words valid this cycle.
- `locked` out 1: state is LOCKED.
- `halt` out 1: state is HALT.
- `resync` out 1: one-cycle request for the pattern generator to reseed.
- `err_total` out 16: saturating count of errors seen while LOCKED.
- `err_pulse` out 1: an aligned mismatch result was seen this cycle.

## Operation
- States are IDLE, HUNT, LOCKED, HALT. Reset enters IDLE.
- Comparator results: `mismatch_32` gets `din_valid` directly. The controller keeps its own 3-deep valid pipeline `v3`.
  - An aligned result exists on a cycle where `v3` is 1.
  - It is an error if `mismatch` is 1, otherwise a match.
- IDLE: when `enable`=1, go to HUNT next cycle and clear all counters.
- HUNT:
  - Each match increments `run` (8 bits).
  - Each error clears `run` and pulses `resync`.
  - When `run` reaches `LOCK_RUN`, go to LOCKED and clear the window counters.
- LOCKED:
  - Each aligned result increments `win_cnt`. Each error increments `win_err` and `err_total` (both saturating).
  - When `win_cnt` reaches `WIN_LEN`, clear `win_cnt` and `win_err`. An error on that same cycle is counted into the new window.
  - When `win_err` reaches `WIN_ERRS`, go to HUNT, pulse `resync`, and clear `run`.
  - When `err_total` reaches `HALT_ERRS`, go to HALT. HALT takes priority over HUNT if both fire on the same cycle.
- HALT:
  - Comparator results are ignored and counters are frozen.
  - `clear` goes to HUNT and zeroes `err_total`.
- `enable`=0 in any state goes to IDLE next cycle. `err_total` is kept, not zeroed.
- `clear` outside HALT only zeroes `err_total`.
- Priority: reset > `enable`=0 > `clear` > result-driven transitions.
- `err_pulse` is 1 for any aligned error in HUNT or LOCKED, and 0 in IDLE and HALT.

## Timing
- Reset values: `locked`=0, `halt`=0, `resync`=0, `err_total`=0, `err_pulse`=0. State is IDLE and all counters are 0.
- All outputs are registered.
- A word presented at cycle t has its aligned result at t+3. The resulting state, counter and `err_pulse` updates are visible at t+4.
- The shortest lock from the first valid word is cycle `LOCK_RUN`+3 for the result, with `locked` high one cycle later.
- `resync` is exactly one cycle wide. It never asserts in IDLE or HALT.
- Words still in the comparator pipeline when the FSM enters IDLE or HALT are discarded. After re-entering HUNT, only results whose `v3` was launched after the transition are counted; `v3` is flushed on entry to IDLE.
- `rst_n` deassertion mid-stream: the comparator pipeline is unreset, so `v3` alone gates validity. Stale comparator output is never counted.

## Structure
- Shared package `sl3p_chk_pkg` holds:
  - the state enum: IDLE=0, HUNT=1, LOCKED=2, HALT=3;
  - the counter width constants: RUN_W=8, WIN_W=16, ERR_W=16;
  - the pipeline constant CMP_LAT=3.
- One sub-module is natural: the existing `mismatch_32`, instantiated once. All counters and the FSM live in `lane_check_ctrl`.

## Test plan
- **Clean lock.** Set `enable`=1, then send 64 valid equal words → `locked` rises at cycle 68 after the first word, with no `resync` and `err_total`=0.
- **Hunt error.** Send 10 matches, 1 mismatch, then 64 matches → one `resync` pulse 4 cycles after the bad word, and lock achieved only after the full 64-run.
- **Window loss.** With WIN_LEN=16 and WIN_ERRS=3, while LOCKED inject 3 errors within 16 words → back to HUNT, `resync` pulsed, `err_total`=3.
- **Window roll.** With WIN_LEN=16 and WIN_ERRS=3, inject 2 errors per window for 4 windows → stays LOCKED and `err_total`=8.
- **Halt and clear.** With HALT_ERRS=5, cause 5 errors while LOCKED → `halt`=1, and further mismatches leave `err_total`=5. A `clear` pulse → HUNT with `err_total`=0.
- **Reset and disable.** Assert `rst_n`=0 while LOCKED with `err_total`=2 → all outputs 0 immediately. In a separate run, drop `enable` while LOCKED → IDLE next cycle with `err_total` retained.
